// File: rtl/conv_row_feeder.sv
// conv_row_feeder
//   Double-buffered row feeder for a KX x KX convolution engine. Pixels are
//   streamed into a shadow row while the consumer works on the active row;
//   once the consumer reports kernel_loop_done the shadow row is swapped in.
//   A small FSM loads the KX*KX kernel weights and can be asked to reload
//   them. A reload takes effect only between rows.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    pixel stream in        in_ready     backpressure
//   w_valid/w_data      weight stream in       w_ready      backpressure
//   weight_reload       request to replace the weight set (honoured in W_READY)
//   kernel_loop_done    consumer has finished the presented row
//   pixel_row           padded active row, element i at [i*RES +: RES]
//   weights             kernel, element k at [k*RES +: RES]
//   pixel_ready         pixel_row valid and held stable
//   weight_ready        weights complete and held stable
//   row_count           rows retired, wraps at 16 bits
module conv_row_feeder #(
    parameter  int KX  = 3,
    parameter  int PIX = 3,
    parameter  int RES = 8,
    localparam int W   = PIX + 2 * (KX / 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [RES-1:0]    in_data,
    output logic              in_ready,
    input  logic              w_valid,
    input  logic [RES-1:0]    w_data,
    output logic              w_ready,
    input  logic              weight_reload,
    input  logic              kernel_loop_done,
    output logic [W*RES-1:0]  pixel_row,
    output logic [KX*KX*RES-1:0] weights,
    output logic              pixel_ready,
    output logic              weight_ready,
    output logic [15:0]       row_count
);

    localparam int HALF = KX / 2;
    localparam int NW   = KX * KX;
    localparam int FW   = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int WW   = $clog2(NW);

    typedef enum logic {W_LOAD, W_READY} wstate_t;

    // Only the PIX interior elements are stored; the pads are tied to zero.
    logic [PIX-1:0][RES-1:0] act_buf;
    logic [PIX-1:0][RES-1:0] shd_buf;
    logic                    act_full;
    logic                    shd_full;
    logic [FW-1:0]           fill_cnt;
    logic [NW-1:0][RES-1:0]  w_reg;
    logic [WW-1:0]           w_cnt;
    logic                    reload_pend;
    wstate_t                 wstate;
    logic [15:0]             row_cnt_q;

    logic in_fire;
    logic w_fire;
    logic done_ev;
    logic swap;
    logic reload_go;

    assign in_ready     = !shd_full;
    assign w_ready      = (wstate == W_LOAD);
    assign weight_ready = (wstate == W_READY);
    assign pixel_ready  = act_full;
    assign row_count    = row_cnt_q;
    assign weights      = w_reg;

    assign in_fire = in_valid && !shd_full;
    assign w_fire  = w_valid && (wstate == W_LOAD);
    assign done_ev = kernel_loop_done && act_full;

    // A pending reload holds the shadow row back so the next row is never
    // presented against a half-written weight set.
    assign swap = shd_full && !reload_pend && (wstate == W_READY) &&
                  (!act_full || kernel_loop_done);

    // A reload waits for the current row to retire before dropping the weights.
    assign reload_go = reload_pend && (!act_full || kernel_loop_done);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row
            if (gi < HALF || gi >= HALF + PIX) begin : g_pad
                assign pixel_row[gi*RES +: RES] = '0;
            end else begin : g_pix
                assign pixel_row[gi*RES +: RES] = act_buf[gi-HALF];
            end
        end
    endgenerate

    // Row buffers, fill counter and retired-row counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_buf   <= '0;
            shd_buf   <= '0;
            act_full  <= 1'b0;
            shd_full  <= 1'b0;
            fill_cnt  <= '0;
            row_cnt_q <= '0;
        end else begin
            // in_fire needs shd_full=0 and swap needs shd_full=1, so the
            // two updates of shd_full/shd_buf never collide.
            if (in_fire) begin
                shd_buf[fill_cnt] <= in_data;
                if (fill_cnt == FW'(PIX - 1)) begin
                    shd_full <= 1'b1;
                    fill_cnt <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            if (swap) begin
                act_buf  <= shd_buf;
                act_full <= 1'b1;
                shd_full <= 1'b0;
            end else if (done_ev) begin
                act_full <= 1'b0;
            end
            if (done_ev)
                row_cnt_q <= row_cnt_q + 16'd1;
        end
    end

    // Weight load FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= W_LOAD;
            w_cnt       <= '0;
            reload_pend <= 1'b0;
            w_reg       <= '0;
        end else begin
            case (wstate)
                W_LOAD: begin
                    if (w_fire) begin
                        w_reg[w_cnt] <= w_data;
                        if (w_cnt == WW'(NW - 1)) begin
                            w_cnt  <= '0;
                            wstate <= W_READY;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                W_READY: begin
                    if (reload_go) begin
                        reload_pend <= 1'b0;
                        wstate      <= W_LOAD;
                    end else if (weight_reload) begin
                        reload_pend <= 1'b1;
                    end
                end
                default: wstate <= W_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Testbench for conv_row_feeder (KX=3, PIX=3, RES=8): directed scenarios
// followed by a randomized run, all compared against a behavioural model.
module tb_conv_row_feeder;

    localparam int KX   = 3;
    localparam int PIX  = 3;
    localparam int RES  = 8;
    localparam int HALF = KX / 2;
    localparam int W    = PIX + 2 * HALF;
    localparam int NW   = KX * KX;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [RES-1:0]    in_data;
    logic              in_ready;
    logic              w_valid;
    logic [RES-1:0]    w_data;
    logic              w_ready;
    logic              weight_reload;
    logic              kernel_loop_done;
    logic [W*RES-1:0]  pixel_row;
    logic [NW*RES-1:0] weights;
    logic              pixel_ready;
    logic              weight_ready;
    logic [15:0]       row_count;

    conv_row_feeder #(.KX(KX), .PIX(PIX), .RES(RES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .weight_reload(weight_reload), .kernel_loop_done(kernel_loop_done),
        .pixel_row(pixel_row), .weights(weights),
        .pixel_ready(pixel_ready), .weight_ready(weight_ready),
        .row_count(row_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: rows as arrays of words, weights as an array,
    // flags as plain bits.
    logic [RES-1:0] m_act[PIX];
    logic [RES-1:0] m_shd[PIX];
    logic [RES-1:0] m_w[NW];
    bit m_afull, m_sfull, m_wrdy, m_pend;
    int m_fill, m_wcnt;
    logic [15:0] m_rows;

    task automatic model_edge();
        bit acc, wacc, dn, sw, go;
        if (rst) begin
            m_afull = 0; m_sfull = 0; m_wrdy = 0; m_pend = 0;
            m_fill = 0; m_wcnt = 0; m_rows = 0;
            for (int i = 0; i < PIX; i++) begin m_act[i] = 0; m_shd[i] = 0; end
            for (int k = 0; k < NW; k++) m_w[k] = 0;
        end else begin
            acc  = in_valid && !m_sfull;
            wacc = w_valid && !m_wrdy;
            dn   = kernel_loop_done && m_afull;
            sw   = m_sfull && !m_pend && m_wrdy && (!m_afull || kernel_loop_done);
            go   = m_pend && (!m_afull || kernel_loop_done);
            if (sw) begin
                m_act = m_shd; m_afull = 1; m_sfull = 0;
            end else if (dn) begin
                m_afull = 0;
            end
            if (dn) m_rows = m_rows + 16'd1;
            if (acc) begin
                m_shd[m_fill] = in_data;
                if (m_fill == PIX - 1) begin m_sfull = 1; m_fill = 0; end
                else m_fill++;
            end
            if (!m_wrdy) begin
                if (wacc) begin
                    m_w[m_wcnt] = w_data;
                    if (m_wcnt == NW - 1) begin m_wrdy = 1; m_wcnt = 0; end
                    else m_wcnt++;
                end
            end else if (go) begin
                m_wrdy = 0; m_pend = 0;
            end else if (weight_reload) begin
                m_pend = 1;
            end
        end
    endtask

    task automatic chk_outs();
        logic [W*RES-1:0]  er;
        logic [NW*RES-1:0] ew;
        er = '0;
        for (int i = 0; i < PIX; i++) er[(i+HALF)*RES +: RES] = m_act[i];
        for (int k = 0; k < NW; k++) ew[k*RES +: RES] = m_w[k];
        chk("pixel_ready",  pixel_ready,  m_afull);
        chk("weight_ready", weight_ready, m_wrdy);
        chk("in_ready",     in_ready,     !m_sfull);
        chk("w_ready",      w_ready,      !m_wrdy);
        chk("row_count",    row_count,    m_rows);
        chk("pixel_row",    pixel_row,    er);
        chk("weights",      weights,      ew);
    endtask

    // Inputs are set at the negedge, model advances with the edge, and
    // outputs are compared at the following negedge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk_outs();
    endtask

    task automatic clr_in();
        rst = 0; in_valid = 0; in_data = 0; w_valid = 0; w_data = 0;
        weight_reload = 0; kernel_loop_done = 0;
    endtask

    task automatic idle(); clr_in(); tick(); endtask
    task automatic push_px(input logic [RES-1:0] d);
        clr_in(); in_valid = 1; in_data = d; tick();
    endtask
    task automatic push_w(input logic [RES-1:0] d);
        clr_in(); w_valid = 1; w_data = d; tick();
    endtask
    task automatic done_pulse(); clr_in(); kernel_loop_done = 1; tick(); endtask

    initial begin
        clr_in();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_pixel_ready", pixel_ready, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_w_ready", w_ready, 1'b1);
        chk("rst_pixel_row", pixel_row, 0);
        idle();

        // Basic load: weights 1..9, pixels 10,20,30.
        for (int k = 1; k <= NW; k++) push_w(RES'(k));
        chk("wload_done", weight_ready, 1'b1);
        chk("wload_vals", weights, 72'h090807060504030201);
        push_px(8'd10); push_px(8'd20); push_px(8'd30);
        chk("lat_not_yet", pixel_ready, 1'b0);
        idle();
        chk("lat_ready", pixel_ready, 1'b1);
        chk("row_A", pixel_row, 40'h001E140A00);

        // Row B waits in shadow, swapped in on done.
        push_px(8'd1); push_px(8'd2); push_px(8'd3);
        chk("shadow_full_stall", in_ready, 1'b0);
        chk("A_held", pixel_row, 40'h001E140A00);
        done_pulse();
        chk("swap_B", pixel_row, 40'h0003020100);
        chk("swap_ready", pixel_ready, 1'b1);
        chk("rows_1", row_count, 16'd1);

        // Last word of C lands on B's done edge.
        push_px(8'd4); push_px(8'd5);
        clr_in(); in_valid = 1; in_data = 8'd6; kernel_loop_done = 1; tick();
        chk("gap_ready", pixel_ready, 1'b0);
        chk("gap_in_ready", in_ready, 1'b0);
        idle();
        chk("C_ready", pixel_ready, 1'b1);
        chk("C_row", pixel_row, 40'h0006050400);

        // Reload mid-row.
        clr_in(); in_valid = 1; in_data = 8'd7; weight_reload = 1; tick();
        push_px(8'd8); push_px(8'd9);
        chk("reload_w_held", weights, 72'h090807060504030201);
        chk("reload_wr_held", weight_ready, 1'b1);
        done_pulse();
        chk("reload_wr_low", weight_ready, 1'b0);
        chk("reload_no_swap", pixel_ready, 1'b0);
        for (int k = 0; k < NW; k++) push_w(RES'(101 + k));
        chk("reload_wr_high", weight_ready, 1'b1);
        chk("reload_D_wait", pixel_ready, 1'b0);
        idle();
        chk("reload_D_ready", pixel_ready, 1'b1);
        chk("reload_D_row", pixel_row, 40'h0009080700);

        // Done with nothing presented is ignored; reset mid-row discards.
        done_pulse();
        chk("rows_4", row_count, 16'd4);
        done_pulse();
        chk("ignored_done", row_count, 16'd4);
        push_px(8'd11); push_px(8'd12);
        clr_in(); rst = 1; tick();
        idle(); idle();
        chk("post_rst_ready", pixel_ready, 1'b0);
        chk("post_rst_rows", row_count, 16'd0);
        for (int k = 0; k < NW; k++) push_w(RES'(k + 2));
        push_px(8'd13); push_px(8'd14); push_px(8'd15);
        idle();
        chk("post_rst_row", pixel_row, 40'h000F0E0D00);

        // row_count wrap: preload near the top of the range.
        dut.row_cnt_q = 16'hFFFE;
        m_rows = 16'hFFFE;
        push_px(8'd21); push_px(8'd22); push_px(8'd23);
        done_pulse();
        chk("rows_ffff", row_count, 16'hFFFF);
        done_pulse();
        chk("rows_wrap", row_count, 16'h0000);

        // Randomized run.
        for (int c = 0; c < 4000; c++) begin
            clr_in();
            rst              = ($urandom_range(0, 299) == 0);
            in_valid         = ($urandom_range(0, 1) == 1);
            in_data          = RES'($urandom);
            w_valid          = ($urandom_range(0, 2) != 0);
            w_data           = RES'($urandom);
            weight_reload    = ($urandom_range(0, 39) == 0);
            kernel_loop_done = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_row_feeder.md
CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

Interface
REQ-001 Parameter KX, 3, square kernel size; odd, >=3.
REQ-002 Parameter PIX, 3, pixels produced per row segment, >=1.
REQ-003 Parameter RES, 8, bits per pixel and per weight.
REQ-004 Parameter W = PIX+2*(KX/2) is derived, not overridable: padded row length.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 in_valid  in  1  pixel stream word valid.
REQ-008 in_data  in  RES  pixel stream word.
REQ-009 in_ready  out  1  feeder accepts in_data this cycle.
REQ-010 w_valid  in  1  weight stream word valid.
REQ-011 w_data  in  RES  weight stream word; row-major kernel order.
REQ-012 w_ready  out  1  feeder accepts w_data this cycle.
REQ-013 weight_reload  in  1  single-cycle request to replace the weight set.
REQ-014 kernel_loop_done  in  1  consumer finished all KX*KX steps on the presented row.
REQ-015 pixel_row  out  W*RES  padded row; element i at bits [i*RES +: RES].
REQ-016 weights  out  KX*KX*RES  kernel; element k at bits [k*RES +: RES].
REQ-017 pixel_ready  out  1  pixel_row valid and held stable.
REQ-018 weight_ready  out  1  all KX*KX weights loaded and held stable.
REQ-019 row_count  out  16  rows retired by kernel_loop_done; wraps 0xFFFF->0.

Function
REQ-020 Two row buffers (active, shadow); pixel_row always drives active; each has a full flag.
REQ-021 Shadow fill: in_ready = !shadow_full; on in_valid&&in_ready, word goes to shadow element KX/2+fill_cnt; fill_cnt increments.
REQ-022 Accepting the word with fill_cnt==PIX-1 sets shadow_full and clears fill_cnt the following cycle.
REQ-023 Pad elements 0..KX/2-1 and W-KX/2..W-1 of both buffers are constant zero.
REQ-024 pixel_ready = active_full (registered).
REQ-025 Swap: copy shadow to active, set active_full, clear shadow_full in one edge; needs registered shadow_full=1, reload not pending, weight_ready=1.
REQ-026 Swap occurs when active_full=0, or when active_full=1 and kernel_loop_done=1.
REQ-027 kernel_loop_done with pixel_ready=1 increments row_count; with no swap, active_full clears.
REQ-028 kernel_loop_done with pixel_ready=0 is ignored.
REQ-029 pixel_row never changes while pixel_ready=1, except at a swap on the done edge.
REQ-030 Latency: last row word accepted at edge t, active empty -> pixel_ready=1 after edge t+1.
REQ-031 Last shadow word accepted on the same edge as kernel_loop_done -> no swap that edge; pixel_ready low one cycle, swap next edge.
REQ-032 Weight FSM states: W_LOAD (w_ready=1, weight_ready=0), W_READY (w_ready=0, weight_ready=1).
REQ-033 W_LOAD stores w_data at index w_cnt per handshake; on index KX*KX-1, go to W_READY, clear w_cnt.
REQ-034 weight_reload in W_READY sets reload_pend; in W_LOAD it is ignored.
REQ-035 reload_pend with active_full=0 -> W_LOAD next edge, reload_pend cleared.
REQ-036 reload_pend with active_full=1 -> wait for kernel_loop_done; that edge clears active_full, enters W_LOAD, blocks swap.
REQ-037 Shadow fill continues in all weight states.

Reset
REQ-038 rst=1: active_full=0, shadow_full=0, fill_cnt=0, w_cnt=0, reload_pend=0, row_count=0, weight FSM W_LOAD.
REQ-039 Outputs during and after reset: pixel_ready=0, weight_ready=0, in_ready=1, w_ready=1, pixel_row=0, weights=0.
REQ-040 rst mid-row or mid-weight-load discards partial data; no pixel_ready or weight_ready pulse results.

Verification
REQ-041 KX=3,PIX=3: weights 1..9, pixels 10,20,30 -> weight_ready=1; pixel_row={0,10,20,30,0}; pixel_ready=1 two edges after the last pixel.
REQ-042 Stream rows A then B, done pulsed while shadow full -> pixel_row switches to B at the done edge, pixel_ready stays 1, row_count=1.
REQ-043 Last word of B on the done edge of A -> pixel_ready 0 one cycle, then B presented; in_ready low while shadow full.
REQ-044 weight_reload mid-row -> weights unchanged until done; then weight_ready=0, no swap; new 9 weights -> weight_ready=1, B presented next edge.
REQ-045 kernel_loop_done with pixel_ready=0; rst after 2 of 3 pixels -> row_count unchanged, no spurious pixel_ready; next full row presented normally.
REQ-046 row_count at 0xFFFF plus one done -> 0x0000.
